// File: rtl/sram_1rw_arbiter_if.sv
// Requester-side handshake bundle for the shared 1RW SRAM arbiter:
// a write channel, a read request channel and a read response channel.
interface sram_1rw_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;

  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_resp_data;

  // Pipeline stage side: issues requests, consumes responses.
  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req_valid, rd_req_addr,
    output rd_resp_ready,
    input  wr_ready, rd_req_ready,
    input  rd_resp_valid, rd_resp_data
  );

  // Arbiter side.
  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_req_addr,
    input  rd_resp_ready,
    output wr_ready, rd_req_ready,
    output rd_resp_valid, rd_resp_data
  );

endinterface

// File: rtl/sram_1rw_arbiter.sv
// Shares one single-port SRAM macro between a write requester and a read
// requester. One access per cycle, round-robin on conflict. Read data comes
// back one cycle after issue and lands in a 2-entry response FIFO; a read is
// only issued when a FIFO slot is already reserved for it, so consumer
// back-pressure never drops data.
//
// rr_prio state | meaning
// PRIO_READ     | read side wins the next contested cycle (reset value)
// PRIO_WRITE    | write side wins the next contested cycle
module sram_1rw_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  sram_1rw_arbiter_if.slave  bus,
  output logic               sram_en,
  output logic               sram_wmode,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata
);

  typedef enum logic [1:0] {GRANT_NONE, GRANT_WRITE, GRANT_READ} grant_t;
  typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

  grant_t            grant;
  prio_t             rr_prio;
  prio_t             rr_prio_next;
  logic              armed;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_count;
  logic [1:0]        occupancy;
  logic              rd_ok;
  logic              wr_elig;
  logic              rd_elig;
  logic              push;
  logic              pop;

  // A read in flight already owns a FIFO slot; count it at issue time.
  assign occupancy = fifo_count + {1'b0, inflight};
  assign rd_ok     = (occupancy < 2'd2);

  // armed stays low through reset and the first cycle after it, so the
  // macro sees no access until the control state has settled.
  assign wr_elig = armed & bus.wr_valid;
  assign rd_elig = armed & bus.rd_req_valid & rd_ok;

  // Grant selection and round-robin update; priority only moves on a contested cycle.
  always_comb begin
    grant        = GRANT_NONE;
    rr_prio_next = rr_prio;
    if (wr_elig && rd_elig) begin
      if (rr_prio == PRIO_READ) begin
        grant        = GRANT_READ;
        rr_prio_next = PRIO_WRITE;
      end else begin
        grant        = GRANT_WRITE;
        rr_prio_next = PRIO_READ;
      end
    end else if (wr_elig) begin
      grant = GRANT_WRITE;
    end else if (rd_elig) begin
      grant = GRANT_READ;
    end
  end

  // Handshake readies and macro controls follow the grant; all zero when idle.
  always_comb begin
    bus.wr_ready     = 1'b0;
    bus.rd_req_ready = 1'b0;
    sram_en          = 1'b0;
    sram_wmode       = 1'b0;
    sram_addr        = '0;
    sram_wdata       = '0;
    case (grant)
      GRANT_WRITE: begin
        bus.wr_ready = 1'b1;
        sram_en      = 1'b1;
        sram_wmode   = 1'b1;
        sram_addr    = bus.wr_addr;
        sram_wdata   = bus.wr_data;
      end
      GRANT_READ: begin
        bus.rd_req_ready = 1'b1;
        sram_en          = 1'b1;
        sram_addr        = bus.rd_req_addr;
      end
      default: ;
    endcase
  end

  // Control state: arming after reset, round-robin priority, read-in-flight flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed    <= 1'b0;
      rr_prio  <= PRIO_READ;
      inflight <= 1'b0;
    end else begin
      armed    <= 1'b1;
      rr_prio  <= rr_prio_next;
      inflight <= (grant == GRANT_READ);
    end
  end

  // sram_rdata is only meaningful the cycle after a read issue.
  assign push = inflight;
  assign pop  = bus.rd_resp_valid & bus.rd_resp_ready;

  assign bus.rd_resp_valid = (fifo_count != 2'd0);
  assign bus.rd_resp_data  = bus.rd_resp_valid ? fifo_mem[rd_ptr] : '0;

  // Response FIFO; simultaneous push and pop is legal at any occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Slot reservation at issue means a capture can never find the FIFO full.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (fifo_count == 2'd2)));

endmodule
